// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hard-wired to zero, optional write-to-read
// bypass, and a clear sequencer that sweeps the array to zero after reset or on request.
module regfile_mp #(
    parameter  int unsigned XLEN   = 32,
    parameter  int unsigned NREGS  = 32,
    parameter  int unsigned NREAD  = 2,
    parameter  int unsigned NWRITE = 2,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    output logic                     busy,
    input  logic [NWRITE-1:0]        wen,
    input  logic [NWRITE*AW-1:0]     waddr,
    input  logic [NWRITE*XLEN-1:0]   wdata,
    input  logic [NREAD*AW-1:0]      raddr,
    output logic [NREAD*XLEN-1:0]    rdata,
    output logic [0:0]               state_o
);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] regs_q [NREGS];

    assign busy    = (state_q == S_CLEAR);
    assign state_o = state_q;

    // cnt starts at 1: x0 is never stored, so the sweep takes NREGS-1 edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = AW'(1);
                end
            end
            default: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = AW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Later write ports are issued last, so the highest index wins a collision.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            regs_q[cnt_q] <= '0;
        end else if (!clr_req) begin
            for (int k = 0; k < NWRITE; k++) begin
                if (wen[k] && (waddr[k*AW +: AW] != '0)) begin
                    regs_q[waddr[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int j = 0; j < NREAD; j++) begin
            if (!busy && (raddr[j*AW +: AW] != '0)) begin
                rdata[j*XLEN +: XLEN] = regs_q[raddr[j*AW +: AW]];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NWRITE; k++) begin
                        if (wen[k] && (waddr[k*AW +: AW] == raddr[j*AW +: AW])) begin
                            rdata[j*XLEN +: XLEN] = wdata[k*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one bypassing and one non-bypassing instance share stimulus;
// table-driven read/write vectors plus hand-written clear and reset sequences.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        clr_req;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [9:0]  raddr;
    logic        busy_b, busy_n;
    logic [63:0] rdata_b, rdata_n;
    logic [0:0]  state_b, state_n;

    int tests = 0;
    int fails = 0;

    regfile_mp #(.BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_b),
        .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_b), .state_o(state_b)
    );

    regfile_mp #(.BYPASS(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_n),
        .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_n), .state_o(state_n)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;   // bypass instance, read port 0
        logic [31:0] e1;   // bypass instance, read port 1
        logic [31:0] n0;   // non-bypass instance, read port 0
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(logic [1:0] w, logic [4:0] a0, logic [31:0] d0,
                                logic [4:0] a1, logic [31:0] d1, logic [4:0] r0,
                                logic [4:0] r1, logic [31:0] x0, logic [31:0] x1,
                                logic [31:0] y0);
        vec_t v;
        v.wen = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
        v.ra0 = r0; v.ra1 = r1; v.e0 = x0; v.e1 = x1; v.n0 = y0;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] r0, input logic [4:0] r1);
        wen   = w;
        waddr = {a1, a0};
        wdata = {d1, d0};
        raddr = {r1, r0};
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts posedges until busy drops, sampled #1 after each edge.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy_b === 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i += 2) begin
            @(negedge clk);
            drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(i), 5'(i + 1));
            #1;
            chk($sformatf("%s.byp.x%0d", tag, i),     rdata_b[31:0],  32'h0);
            chk($sformatf("%s.byp.x%0d", tag, i + 1), rdata_b[63:32], 32'h0);
            chk($sformatf("%s.nob.x%0d", tag, i),     rdata_n[31:0],  32'h0);
            chk($sformatf("%s.nob.x%0d", tag, i + 1), rdata_n[63:32], 32'h0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;

        vecs[0]  = mk(2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
        vecs[1]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF);
        vecs[2]  = mk(2'b11, 5'd7,  32'h1111,     5'd7,  32'h2222,     5'd7,  5'd5,  32'h2222,     32'hDEADBEEF, 32'h0);
        vecs[3]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd7,  5'd7,  32'h2222,     32'h2222,     32'h2222);
        vecs[4]  = mk(2'b10, 5'd0,  32'h0,        5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0);
        vecs[5]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h2222,     32'h0);
        vecs[6]  = mk(2'b11, 5'd9,  32'hAAAA,     5'd10, 32'hBBBB,     5'd10, 5'd9,  32'hBBBB,     32'hAAAA,     32'h0);
        vecs[7]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd10, 32'hAAAA,     32'hBBBB,     32'hAAAA);
        vecs[8]  = mk(2'b01, 5'd9,  32'hCCCC,     5'd0,  32'h0,        5'd9,  5'd9,  32'hCCCC,     32'hCCCC,     32'hAAAA);
        vecs[9]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd31, 32'hCCCC,     32'h0,        32'hCCCC);
        vecs[10] = mk(2'b10, 5'd0,  32'h0,        5'd31, 32'h12345678, 5'd31, 5'd30, 32'h12345678, 32'h0,        32'h0);
        vecs[11] = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd31, 5'd7,  32'h12345678, 32'h2222,     32'h12345678);
        vecs[12] = mk(2'b11, 5'd31, 32'h5555,     5'd30, 32'h6666,     5'd31, 5'd30, 32'h5555,     32'h6666,     32'h12345678);
        vecs[13] = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd31, 5'd30, 32'h5555,     32'h6666,     32'h5555);

        // Reset state; writes are held active throughout the first sweep.
        rst_n   = 1'b0;
        clr_req = 1'b0;
        drive(2'b11, 5'd5, 32'h5A5A5A5A, 5'd7, 32'hA5A5A5A5, 5'd5, 5'd7);
        repeat (3) @(negedge clk);
        #1;
        chk("reset.busy", 32'(busy_b), 32'h1);
        chk("reset.rdata0", rdata_b[31:0], 32'h0);
        chk("reset.rdata1", rdata_b[63:32], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("sweep.busy_mid", 32'(busy_b), 32'h1);
        chk("sweep.bypass_blocked", rdata_b[31:0], 32'h0);
        wait_idle(n);
        n = n + 5;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        chk("sweep.busy_cycles", 32'(n), 32'd31);
        chk("sweep.busy_after", 32'(busy_b), 32'h0);
        read_all_zero("init");

        // Table-driven single-cycle vectors.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].wen, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
                  vecs[i].ra0, vecs[i].ra1);
            #1;
            chk($sformatf("vec%0d.byp.r0", i), rdata_b[31:0],  vecs[i].e0);
            chk($sformatf("vec%0d.byp.r1", i), rdata_b[63:32], vecs[i].e1);
            chk($sformatf("vec%0d.nob.r0", i), rdata_n[31:0],  vecs[i].n0);
        end

        // Load x1..x31 with their index, then clear with a simultaneous write to x3.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(2'b01, 5'(i), 32'(i), 5'd0, 32'h0, 5'd0, 5'd0);
        end
        @(negedge clk);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd31);
        #1;
        chk("load.x3", rdata_n[31:0], 32'd3);
        chk("load.x31", rdata_n[63:32], 32'd31);
        @(negedge clk);
        clr_req = 1'b1;
        drive(2'b01, 5'd3, 32'hFFFF, 5'd0, 32'h0, 5'd3, 5'd3);
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd3);
        chk("clr.busy_start", 32'(busy_b), 32'h1);
        wait_idle(n);
        chk("clr.busy_cycles", 32'(n), 32'd31);
        read_all_zero("clr");

        // Reset asserted 10 edges into a sweep restarts it from the beginning.
        @(negedge clk);
        drive(2'b01, 5'd4, 32'h44, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd0);
        #1;
        chk("rst.x4_loaded", rdata_n[31:0], 32'h44);
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst.busy_in_reset", 32'(busy_b), 32'h1);
        chk("rst.state", 32'(state_b), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle(n);
        chk("rst.busy_cycles", 32'(n), 32'd31);
        chk("rst.nob_busy", 32'(busy_n), 32'h0);
        read_all_zero("rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
